// File: rtl/pc_mon_pkg.sv
// Shared types and defaults for the PC trap monitor.
// Holds the verdict FSM encoding, print-region defaults and a width helper.
package pc_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } mon_state_e;

  localparam logic [63:0] PRINT_BASE_DFLT  = 64'h0000_0000_8000_0400;
  localparam int          PRINT_SHIFT_DFLT = 9;

  // Index width that never collapses to zero bits for a single hart.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pc_mon_hart.sv
// Per-hart lane: input register, trap compare, print detect, watchdog
// counter and sticky good bit.
module pc_mon_hart
  import pc_mon_pkg::*;
#(
  parameter int              NUM_TRAPS   = 2,
  parameter int              PC_W        = 64,
  parameter int              TMO_W       = 32,
  parameter logic [PC_W-1:0] PRINT_BASE  = PC_W'(PRINT_BASE_DFLT),
  parameter int              PRINT_SHIFT = PRINT_SHIFT_DFLT
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      hart_en,
  input  logic                      run,
  input  logic                      pc_vld,
  input  logic [PC_W-1:0]           pc,
  input  logic [NUM_TRAPS*PC_W-1:0] good_trap,
  input  logic [NUM_TRAPS-1:0]      good_trap_vld,
  input  logic [NUM_TRAPS*PC_W-1:0] bad_trap,
  input  logic [NUM_TRAPS-1:0]      bad_trap_vld,
  input  logic [TMO_W-1:0]          tmo_limit,
  output logic                      bad_hit_s,
  output logic                      expired_s,
  output logic                      good_r,
  output logic                      print_vld_r,
  output logic [7:0]                print_char_r
);

  logic              vld_r;
  logic [PC_W-1:0]   pc_r;
  logic [TMO_W-1:0]  cnt_r;
  logic              good_hit_s;
  logic              in_region_s;

  // Slot compare: full-width equality against every enabled slot.
  always_comb begin
    good_hit_s = 1'b0;
    bad_hit_s  = 1'b0;
    for (int i = 0; i < NUM_TRAPS; i++) begin
      good_hit_s = good_hit_s | (vld_r & good_trap_vld[i] & (pc_r == good_trap[i*PC_W +: PC_W]));
      bad_hit_s  = bad_hit_s  | (vld_r & bad_trap_vld[i]  & (pc_r == bad_trap[i*PC_W +: PC_W]));
    end
    in_region_s = (pc_r >> PRINT_SHIFT) == (PRINT_BASE >> PRINT_SHIFT);
    expired_s   = hart_en & ~good_r & (tmo_limit != {TMO_W{1'b0}}) & (cnt_r == tmo_limit);
  end

  // Lane state; a bad hit on the same PC suppresses the good bit.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_r        <= 1'b0;
      pc_r         <= {PC_W{1'b0}};
      cnt_r        <= {TMO_W{1'b0}};
      good_r       <= 1'b0;
      print_vld_r  <= 1'b0;
      print_char_r <= 8'h00;
    end else begin
      vld_r       <= pc_vld;
      pc_r        <= pc;
      print_vld_r <= vld_r & in_region_s;
      if (vld_r && in_region_s) begin
        print_char_r <= pc_r[8:1];
      end
      if (run && good_hit_s && !bad_hit_s) begin
        good_r <= 1'b1;
      end
      if (!hart_en || good_r || !run || vld_r) begin
        cnt_r <= {TMO_W{1'b0}};
      end else if (cnt_r != {TMO_W{1'b1}}) begin
        cnt_r <= cnt_r + TMO_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_trap_monitor.sv
// Multi-hart retirement monitor: per-hart lanes plus the sticky
// pass/fail/timeout verdict FSM, error-hart encoder and good popcount.
module pc_trap_monitor
  import pc_mon_pkg::*;
#(
  parameter int              NUM_HARTS   = 4,
  parameter int              PC_W        = 64,
  parameter int              NUM_TRAPS   = 2,
  parameter int              TMO_W       = 32,
  parameter logic [PC_W-1:0] PRINT_BASE  = PC_W'(PRINT_BASE_DFLT),
  parameter int              PRINT_SHIFT = PRINT_SHIFT_DFLT
) (
  input  logic                                 clk,
  input  logic                                 rst_l,
  input  logic [NUM_HARTS-1:0]                 hart_en,
  input  logic [NUM_HARTS-1:0]                 pc_vld,
  input  logic [NUM_HARTS*PC_W-1:0]            pc,
  input  logic [NUM_TRAPS*PC_W-1:0]            good_trap,
  input  logic [NUM_TRAPS-1:0]                 good_trap_vld,
  input  logic [NUM_TRAPS*PC_W-1:0]            bad_trap,
  input  logic [NUM_TRAPS-1:0]                 bad_trap_vld,
  input  logic [TMO_W-1:0]                     tmo_limit,
  output logic [NUM_HARTS-1:0]                 hart_good,
  output logic [$clog2(NUM_HARTS+1)-1:0]       good_count,
  output logic [NUM_HARTS-1:0]                 print_vld,
  output logic [NUM_HARTS*8-1:0]               print_char,
  output logic                                 pass,
  output logic                                 fail,
  output logic                                 tmo,
  output logic [clog2_min1(NUM_HARTS)-1:0]     err_hart,
  output logic                                 done
);

  localparam int HW = clog2_min1(NUM_HARTS);
  localparam int CW = $clog2(NUM_HARTS+1);

  mon_state_e            state_r, state_nxt;
  logic [HW-1:0]         err_hart_r, err_nxt;
  logic                  pass_r, fail_r, tmo_r, done_r;
  logic [NUM_HARTS-1:0]  bad_vec_s, exp_vec_s, good_vec_s;
  logic [CW-1:0]         count_s;
  logic                  run_s;

  function automatic logic [HW-1:0] lowest_idx(input logic [NUM_HARTS-1:0] v);
    logic [HW-1:0] idx;
    idx = {HW{1'b0}};
    for (int i = NUM_HARTS-1; i >= 0; i--) begin
      idx = v[i] ? HW'(i) : idx;
    end
    return idx;
  endfunction

  assign run_s = (state_r == ST_RUN);

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    pc_mon_hart #(
      .NUM_TRAPS   (NUM_TRAPS),
      .PC_W        (PC_W),
      .TMO_W       (TMO_W),
      .PRINT_BASE  (PRINT_BASE),
      .PRINT_SHIFT (PRINT_SHIFT)
    ) u_hart (
      .clk           (clk),
      .rst_l         (rst_l),
      .hart_en       (hart_en[h]),
      .run           (run_s),
      .pc_vld        (pc_vld[h]),
      .pc            (pc[h*PC_W +: PC_W]),
      .good_trap     (good_trap),
      .good_trap_vld (good_trap_vld),
      .bad_trap      (bad_trap),
      .bad_trap_vld  (bad_trap_vld),
      .tmo_limit     (tmo_limit),
      .bad_hit_s     (bad_vec_s[h]),
      .expired_s     (exp_vec_s[h]),
      .good_r        (good_vec_s[h]),
      .print_vld_r   (print_vld[h]),
      .print_char_r  (print_char[h*8 +: 8])
    );
  end

  // Popcount of the sticky good bits.
  always_comb begin
    count_s = {CW{1'b0}};
    for (int i = 0; i < NUM_HARTS; i++) begin
      count_s = count_s + CW'(good_vec_s[i]);
    end
  end

  // Verdict next-state: FAIL beats TMO beats PASS; terminal states hold.
  always_comb begin
    state_nxt = state_r;
    err_nxt   = err_hart_r;
    case (state_r)
      ST_RUN: begin
        if (|bad_vec_s) begin
          state_nxt = ST_FAIL;
          err_nxt   = lowest_idx(bad_vec_s);
        end else if (|exp_vec_s) begin
          state_nxt = ST_TMO;
          err_nxt   = lowest_idx(exp_vec_s);
        end else if ((&(good_vec_s | ~hart_en)) && (hart_en != {NUM_HARTS{1'b0}})) begin
          state_nxt = ST_PASS;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TMO: state_nxt = state_r;
      default: state_nxt = ST_RUN;
    endcase
  end

  // State register with registered verdict outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r    <= ST_RUN;
      err_hart_r <= {HW{1'b0}};
      pass_r     <= 1'b0;
      fail_r     <= 1'b0;
      tmo_r      <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      err_hart_r <= err_nxt;
      pass_r     <= (state_nxt == ST_PASS);
      fail_r     <= (state_nxt == ST_FAIL);
      tmo_r      <= (state_nxt == ST_TMO);
      done_r     <= (state_nxt != ST_RUN);
    end
  end

  assign hart_good  = good_vec_s;
  assign good_count = count_s;
  assign pass       = pass_r;
  assign fail       = fail_r;
  assign tmo        = tmo_r;
  assign done       = done_r;
  assign err_hart   = err_hart_r;

endmodule
